// File: rtl/fpu_wb_pkg.sv
// fpu_wb_pkg -- shared definitions for the FPU writeback arbiter.
//   Source ids (index into the packed in_* buses and value of wb_src),
//   exception-flag width, divsqrt starvation limit, and the result record
//   {data, tag, exc} laid out at the default result widths.
package fpu_wb_pkg;

  localparam int SRC_FMA    = 0;
  localparam int SRC_DIV    = 1;
  localparam int SRC_SIMPLE = 2;

  localparam int EXC_W      = 5;
  localparam int AGE_LIMIT  = 8;

  // Default recoded-FP result and destination-tag widths.
  localparam int RES_DATA_W = 65;
  localparam int RES_TAG_W  = 5;

  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic [RES_TAG_W-1:0]  tag;
    logic [EXC_W-1:0]      exc;
  } fpu_result_t;

endpackage

// File: rtl/fpu_wb_fifo2.sv
// fpu_wb_fifo2 -- 2-entry fall-through FIFO for a non-stallable result source.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   push, push_data  : incoming beat (always offered, the source cannot wait)
//   pop              : consumer takes the current head this cycle
//   head             : stored head, or push_data directly while empty
//   full, empty      : occupancy flags
// A push into a full FIFO with no pop that cycle is silently not stored; the
// parent detects that case from full/pop and flags it.
module fpu_wb_fifo2 #(
  parameter int W = 75
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         bypass;
  logic         rd_en;
  logic         wr_en;

  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign head   = empty ? push_data : mem[rd_ptr];

  // Empty FIFO whose incoming beat is consumed in the same cycle: nothing stored.
  assign bypass = empty && push && pop;
  assign rd_en  = pop && !empty;
  assign wr_en  = push && !bypass && (!full || rd_en);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  // Payload storage needs no reset; count gates its visibility.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter -- merges fma, divsqrt and simple FPU results onto one
// registered writeback port.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : per-source handshake, [0]=fma [1]=divsqrt [2]=simple;
//                         fma and simple are always ready (2-entry FIFOs),
//                         divsqrt is ready while its holding register is empty
//   in_data/in_tag/in_exc : payloads packed by source index
//   wb_stall            : writeback consumer cannot take the current beat
//   wb_valid/wb_data/wb_tag/wb_exc/wb_src : registered writeback beat
//   ovf_err             : sticky, set when an fma/simple beat is dropped
// Priority fma > simple > divsqrt, except a divsqrt result that has waited
// AGE_LIMIT cycles wins outright.
// Optional macro FPU_WB_ARBITER_ASSERT_EN adds simulation-only $fatal checks
// (multiple grants, overflow, writeback change while stalled).
module fpu_wb_arbiter
  import fpu_wb_pkg::*;
#(
  parameter int DATA_W = 65,
  parameter int TAG_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            in_valid,
  output logic [2:0]            in_ready,
  input  logic [3*DATA_W-1:0]   in_data,
  input  logic [3*TAG_W-1:0]    in_tag,
  input  logic [3*EXC_W-1:0]    in_exc,
  input  logic                  wb_stall,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [EXC_W-1:0]      wb_exc,
  output logic [1:0]            wb_src,
  output logic                  ovf_err
);

  localparam int RES_W = DATA_W + TAG_W + EXC_W;

  logic [RES_W-1:0] in_res [3];
  logic [RES_W-1:0] fma_head, simple_head, div_res, sel_res, wb_res, hold_res;
  logic             fma_full, fma_empty, simple_full, simple_empty;
  logic             fma_cand, simple_cand, div_cand, hold_valid;
  logic             can_load, fma_drop, simple_drop;
  logic [2:0]       grant;
  logic [1:0]       sel_src;
  logic [3:0]       age;

  for (genvar gi = 0; gi < 3; gi++) begin : g_pack
    assign in_res[gi] = {in_data[gi*DATA_W +: DATA_W],
                         in_tag[gi*TAG_W +: TAG_W],
                         in_exc[gi*EXC_W +: EXC_W]};
  end

  fpu_wb_fifo2 #(.W(RES_W)) u_fifo_fma (
    .clock(clock), .reset(reset),
    .push(in_valid[SRC_FMA]), .push_data(in_res[SRC_FMA]), .pop(grant[SRC_FMA]),
    .head(fma_head), .full(fma_full), .empty(fma_empty)
  );

  fpu_wb_fifo2 #(.W(RES_W)) u_fifo_simple (
    .clock(clock), .reset(reset),
    .push(in_valid[SRC_SIMPLE]), .push_data(in_res[SRC_SIMPLE]), .pop(grant[SRC_SIMPLE]),
    .head(simple_head), .full(simple_full), .empty(simple_empty)
  );

  assign in_ready = {1'b1, ~hold_valid, 1'b1};

  // Fall-through: an empty queue presents the incoming beat as its candidate.
  assign fma_cand    = !fma_empty || in_valid[SRC_FMA];
  assign simple_cand = !simple_empty || in_valid[SRC_SIMPLE];
  assign div_cand    = hold_valid || in_valid[SRC_DIV];
  assign div_res     = hold_valid ? hold_res : in_res[SRC_DIV];

  // The writeback register can take a new beat unless it holds a stalled one.
  assign can_load    = !(wb_valid && wb_stall);

  assign fma_drop    = in_valid[SRC_FMA] && fma_full && !grant[SRC_FMA];
  assign simple_drop = in_valid[SRC_SIMPLE] && simple_full && !grant[SRC_SIMPLE];

  always_comb begin
    grant = 3'b000;
    if (can_load) begin
      if (div_cand && age == 4'(AGE_LIMIT)) grant[SRC_DIV]    = 1'b1;
      else if (fma_cand)                    grant[SRC_FMA]    = 1'b1;
      else if (simple_cand)                 grant[SRC_SIMPLE] = 1'b1;
      else if (div_cand)                    grant[SRC_DIV]    = 1'b1;
    end
  end

  always_comb begin
    sel_res = fma_head;
    sel_src = 2'(SRC_FMA);
    if (grant[SRC_SIMPLE]) begin
      sel_res = simple_head;
      sel_src = 2'(SRC_SIMPLE);
    end else if (grant[SRC_DIV]) begin
      sel_res = div_res;
      sel_src = 2'(SRC_DIV);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_res     <= '0;
      wb_src     <= 2'd0;
      ovf_err    <= 1'b0;
      hold_valid <= 1'b0;
      age        <= 4'd0;
    end else begin
      if (|grant) begin
        wb_valid <= 1'b1;
        wb_res   <= sel_res;
        wb_src   <= sel_src;
      end else if (can_load) begin
        wb_valid <= 1'b0;
      end
      ovf_err <= ovf_err | fma_drop | simple_drop;
      // A divsqrt beat granted straight from the input never occupies the register.
      if (grant[SRC_DIV])                            hold_valid <= 1'b0;
      else if (!hold_valid && in_valid[SRC_DIV])     hold_valid <= 1'b1;
      if (grant[SRC_DIV])                            age <= 4'd0;
      else if (div_cand && age != 4'(AGE_LIMIT))     age <= age + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!hold_valid && in_valid[SRC_DIV]) hold_res <= in_res[SRC_DIV];
  end

  assign wb_data = wb_res[RES_W-1 -: DATA_W];
  assign wb_tag  = wb_res[EXC_W +: TAG_W];
  assign wb_exc  = wb_res[EXC_W-1:0];

`ifdef FPU_WB_ARBITER_ASSERT_EN
  always @(posedge clock) begin
    if (!reset) begin
      if ($countones(grant) > 1) $fatal(1, "fpu_wb_arbiter: more than one grant");
      if (fma_drop || simple_drop) $fatal(1, "fpu_wb_arbiter: result queue overflow");
    end
  end

  assert property (@(posedge clock) disable iff (reset)
    (wb_valid && wb_stall) |=> $stable({wb_valid, wb_res, wb_src}))
    else $fatal(1, "fpu_wb_arbiter: writeback changed while stalled");
`else
  // Checks not built; behaviour is identical either way.
`endif

endmodule
